decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I instruction decode stage for the pipelined core. It replaces the combinational one-hot-driven decoder: it takes the raw 32-bit instruction and decodes the opcode itself. It checks the full funct7/funct3 fields, generates the sign-extended immediate, flags illegal encodings and optionally decodes the M extension. The decoded control bundle sits between fetch and execute behind a valid/ready handshake, with a 2-entry skid buffer and a flush input.

## Interface
Parameters:
- XLEN, 32: PC width.
- ENABLE_M, 0: 1 decodes RV32M (opcode 0110011, funct7 0000001); 0 flags those encodings illegal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept; equals NOT skid_valid (registered source).
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  discard all held and incoming instructions.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_pc  out  XLEN  PC of the bundle.
- out_rs1, out_rs2, out_rd  out  5 each  register indices (raw fields).
- out_imm  out  32  sign-extended I/S/B/U/J immediate; 0 for R-type.
- out_alu_ctrl  out  5  ALU operation.
- out_operand_a  out  1  1 = PC (branch, jal, auipc).
- out_operand_b  out  1  1 = immediate (I, load, store, branch, jal, jalr, auipc).
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_lui, out_auipc  out  1 each  control strobes.
- out_mem_size  out  3  funct3 of load/store.
- out_rd_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (lui).
- out_illegal  out  1  encoding is not a legal RV32I[M] instruction.

## Operation
- ALU codes: add 00000, sub 00001, sll 00010, slt 00011, sltu 00100, xor 00101, srl 00110, sra 00111, or 01000, and 01001.
- M codes (ENABLE_M=1): 1_0 followed by funct3 (mul 10000 … remu 10111).
- Load, store, branch, jal, jalr, auipc and lui all use add.
- R-type: funct7 0000000 is legal for all funct3. funct7 0100000 is legal only for funct3 000 (sub) and 101 (sra). Every other funct7 is illegal, except M as above.
- I-type arithmetic ignores imm[11:5], except on shifts. slli/srli need imm[11:5]=0000000; srai needs 0100000; any other value is illegal.
- Legal funct3 values:
  - load: 000, 001, 010, 100, 101
  - store: 000–010
  - branch: all except 010 and 011
  - jalr: 000
- Unknown opcodes are illegal.
- Illegal instructions still flow with out_illegal=1. reg_write, mem_read, mem_write, branch, jal and jalr are forced to 0.
- Decode is combinational on the input side. The bundle is captured into the output register, or into the skid register when the output is held and not accepted.

## Timing
- Reset: out_valid=0, skid_valid=0, in_ready=1. All bundle fields 0.
- Latency: 1 cycle from accept (in_valid & in_ready) to out_valid. Throughput is 1 per cycle while out_ready=1.
- Output register loads when it is empty or out_ready=1. The source is the skid register if skid_valid, otherwise the input.
- An accept while the output is held (out_valid & ~out_ready) goes to the skid register. in_ready goes low on the next cycle.
- out_ready with skid_valid: the skid entry moves to the output and the skid empties. No input is accepted that cycle, because in_ready=0.
- Bundle fields never change while out_valid & ~out_ready.
- Ordering is preserved; no instruction is dropped or duplicated.
- Flush has priority over everything. Next cycle: out_valid=0, skid_valid=0, in_ready=1. An in_valid in the flush cycle is dropped.
- rst_n low mid-stream clears both entries immediately, regardless of clk.

## Structure
- Package decode_pkg holds: opcode constants, ALU code constants, rd_sel codes and the packed decoded-bundle struct type.
- Sub-module decode_comb: purely combinational instr→bundle decoder with an ENABLE_M parameter, instantiated once.
- decode_stage contains only the output register, the skid register and the handshake logic.

## Test plan
- 0x002081B3 (add x3,x1,x2) → next cycle out_valid=1, alu 00000, rs1=1, rs2=2, rd=3, reg_write=1, operand_b=0. 0x402081B3 → alu 00001. 0x4020C1B3 → out_illegal=1, reg_write=0.
- 0xFFC12283 (lw x5,-4(x2)) → imm 0xFFFFFFFC, mem_read=1, mem_size=010, rd_sel=01, operand_b=1.
- 0x008000EF (jal x1,8) → imm 0x00000008, jal=1, operand_a=1, rd_sel=10.
- 0x022081B3 → ENABLE_M=1: alu 10000, legal. ENABLE_M=0: out_illegal=1.
- out_ready=0 with PCs 0x0, 0x4, 0x8 offered back-to-back → 0x0 held at output, 0x4 in skid, in_ready=0 from cycle 2, 0x8 held upstream. Release → 0x0, 0x4, 0x8 in order, each exactly once.
- Both entries full plus in_valid, assert flush → next cycle out_valid=0, in_ready=1, flushed instruction never appears. Assert rst_n low mid-stream → same result asynchronously.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I[M] decode definitions: opcodes, ALU codes, rd_sel codes and the
// decoded control bundle carried between fetch and execute.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_AND  = 5'b01001;
  localparam logic [1:0] ALU_M_PREFIX = 2'b10;

  typedef enum logic [1:0] {
    RD_ALU = 2'b00,
    RD_MEM = 2'b01,
    RD_PC4 = 2'b10,
    RD_IMM = 2'b11
  } rd_sel_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu_ctrl;
    logic        operand_a;
    logic        operand_b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic [2:0]  mem_size;
    rd_sel_e     rd_sel;
    logic        illegal;
  } bundle_t;

  // alt selects the funct7=0100000 variant, which only exists for add/srl
  function automatic logic [4:0] alu_base(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I[M] decoder: raw instruction word in, control bundle out.
module decode_comb
  import decode_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [31:0] instr,
  output bundle_t     bundle
);

  logic signed [31:0] instr_s;
  logic signed [31:0] imm_i;
  logic        [31:0] imm_s, imm_b, imm_u, imm_j;
  logic        [6:0]  opcode, funct7;
  logic        [2:0]  funct3;
  logic               legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Arithmetic shift yields the sign-extended I immediate; other formats reuse its sign bits
  assign instr_s = instr;
  assign imm_i   = instr_s >>> 20;
  assign imm_s   = {imm_i[31:5], instr[11:7]};
  assign imm_b   = {imm_i[31:12], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {instr[31:12], 12'b0};
  assign imm_j   = {imm_i[31:20], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    bundle     = '0;
    bundle.rs1 = instr[19:15];
    bundle.rs2 = instr[24:20];
    bundle.rd  = instr[11:7];
    legal      = 1'b1;
    case (opcode)
      OPC_LUI: begin
        bundle.imm       = imm_u;
        bundle.reg_write = 1'b1;
        bundle.lui       = 1'b1;
        bundle.rd_sel    = RD_IMM;
      end
      OPC_AUIPC: begin
        bundle.imm       = imm_u;
        bundle.operand_a = 1'b1;
        bundle.operand_b = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.auipc     = 1'b1;
      end
      OPC_JAL: begin
        bundle.imm       = imm_j;
        bundle.operand_a = 1'b1;
        bundle.operand_b = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.jal       = 1'b1;
        bundle.rd_sel    = RD_PC4;
      end
      OPC_JALR: begin
        bundle.imm       = imm_i;
        bundle.operand_b = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.jalr      = 1'b1;
        bundle.rd_sel    = RD_PC4;
        legal            = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        bundle.imm       = imm_b;
        bundle.operand_a = 1'b1;
        bundle.operand_b = 1'b1;
        bundle.branch    = 1'b1;
        legal            = (funct3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        bundle.imm       = imm_i;
        bundle.operand_b = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.mem_read  = 1'b1;
        bundle.mem_size  = funct3;
        bundle.rd_sel    = RD_MEM;
        legal            = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      end
      OPC_STORE: begin
        bundle.imm       = imm_s;
        bundle.operand_b = 1'b1;
        bundle.mem_write = 1'b1;
        bundle.mem_size  = funct3;
        legal            = (funct3[2] == 1'b0) && (funct3 != 3'b011);
      end
      OPC_OP_IMM: begin
        bundle.imm       = imm_i;
        bundle.operand_b = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.alu_ctrl  = alu_base(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        // Only the shift forms constrain imm[11:5]
        if (funct3 == 3'b001)
          legal = (funct7 == F7_BASE);
        else if (funct3 == 3'b101)
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      end
      OPC_OP: begin
        bundle.reg_write = 1'b1;
        if (funct7 == F7_BASE)
          bundle.alu_ctrl = alu_base(funct3, 1'b0);
        else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
          bundle.alu_ctrl = alu_base(funct3, 1'b1);
        else if ((funct7 == F7_MULDIV) && (ENABLE_M != 0))
          bundle.alu_ctrl = {ALU_M_PREFIX, funct3};
        else
          legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings still flow but must not cause any architectural side effect
    if (!legal) begin
      bundle.reg_write = 1'b0;
      bundle.mem_read  = 1'b0;
      bundle.mem_write = 1'b0;
      bundle.branch    = 1'b0;
      bundle.jal       = 1'b0;
      bundle.jalr      = 1'b0;
      bundle.alu_ctrl  = ALU_ADD;
    end
    bundle.illegal = ~legal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register plus one skid entry behind a
// valid/ready handshake, with flush and asynchronous reset.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_alu_ctrl,
  output logic            out_operand_a,
  output logic            out_operand_b,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_lui,
  output logic            out_auipc,
  output logic [2:0]      out_mem_size,
  output logic [1:0]      out_rd_sel,
  output logic            out_illegal
);

  bundle_t         dec_p0;
  bundle_t         out_p1, skid_p1;
  logic [XLEN-1:0] out_pc_p1, skid_pc_p1;
  logic            vld_p1, skid_vld_p1;
  logic            accept, load_out;

  decode_comb #(.ENABLE_M(ENABLE_M)) u_decode_comb (
    .instr  (in_instr),
    .bundle (dec_p0)
  );

  assign in_ready = ~skid_vld_p1;
  assign accept   = in_valid & ~skid_vld_p1;
  assign load_out = ~vld_p1 | out_ready;

  // p0 -> p1: decoded bundle lands in the output register, or parks in skid while output is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= '0;
      skid_p1     <= '0;
      out_pc_p1   <= '0;
      skid_pc_p1  <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (load_out) begin
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        out_pc_p1   <= skid_pc_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept;
        if (accept) begin
          out_p1    <= dec_p0;
          out_pc_p1 <= in_pc;
        end
      end
    end else if (accept) begin
      skid_p1     <= dec_p0;
      skid_pc_p1  <= in_pc;
      skid_vld_p1 <= 1'b1;
    end
  end

  assign out_valid     = vld_p1;
  assign out_pc        = out_pc_p1;
  assign out_rs1       = out_p1.rs1;
  assign out_rs2       = out_p1.rs2;
  assign out_rd        = out_p1.rd;
  assign out_imm       = out_p1.imm;
  assign out_alu_ctrl  = out_p1.alu_ctrl;
  assign out_operand_a = out_p1.operand_a;
  assign out_operand_b = out_p1.operand_b;
  assign out_reg_write = out_p1.reg_write;
  assign out_mem_read  = out_p1.mem_read;
  assign out_mem_write = out_p1.mem_write;
  assign out_branch    = out_p1.branch;
  assign out_jal       = out_p1.jal;
  assign out_jalr      = out_p1.jalr;
  assign out_lui       = out_p1.lui;
  assign out_auipc     = out_p1.auipc;
  assign out_mem_size  = out_p1.mem_size;
  assign out_rd_sel    = out_p1.rd_sel;
  assign out_illegal   = out_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M enabled / disabled) on shared inputs,
// checked against an ISA-level reference decoder and an in-order queue model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;

  always #5 clk = ~clk;

  logic        rdy_m, vld_m, opa_m, opb_m, rw_m, mr_m, mw_m, br_m, jal_m, jalr_m, lui_m, auipc_m, ill_m;
  logic [31:0] pc_m, imm_m;
  logic [4:0]  rs1_m, rs2_m, rd_m, alu_m;
  logic [2:0]  msz_m;
  logic [1:0]  rds_m;
  logic        rdy_b, vld_b, opa_b, opb_b, rw_b, mr_b, mw_b, br_b, jal_b, jalr_b, lui_b, auipc_b, ill_b;
  logic [31:0] pc_b, imm_b;
  logic [4:0]  rs1_b, rs2_b, rd_b, alu_b;
  logic [2:0]  msz_b;
  logic [1:0]  rds_b;

  decode_stage #(.XLEN(32), .ENABLE_M(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(vld_m), .out_ready(out_ready), .out_pc(pc_m),
    .out_rs1(rs1_m), .out_rs2(rs2_m), .out_rd(rd_m), .out_imm(imm_m), .out_alu_ctrl(alu_m),
    .out_operand_a(opa_m), .out_operand_b(opb_m), .out_reg_write(rw_m), .out_mem_read(mr_m),
    .out_mem_write(mw_m), .out_branch(br_m), .out_jal(jal_m), .out_jalr(jalr_m),
    .out_lui(lui_m), .out_auipc(auipc_m), .out_mem_size(msz_m), .out_rd_sel(rds_m),
    .out_illegal(ill_m)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(vld_b), .out_ready(out_ready), .out_pc(pc_b),
    .out_rs1(rs1_b), .out_rs2(rs2_b), .out_rd(rd_b), .out_imm(imm_b), .out_alu_ctrl(alu_b),
    .out_operand_a(opa_b), .out_operand_b(opb_b), .out_reg_write(rw_b), .out_mem_read(mr_b),
    .out_mem_write(mw_b), .out_branch(br_b), .out_jal(jal_b), .out_jalr(jalr_b),
    .out_lui(lui_b), .out_auipc(auipc_b), .out_mem_size(msz_b), .out_rd_sel(rds_b),
    .out_illegal(ill_b)
  );

  logic [99:0] obs_m, obs_b;
  assign obs_m = {pc_m, rs1_m, rs2_m, rd_m, imm_m, alu_m, opa_m, opb_m, rw_m, mr_m, mw_m,
                  br_m, jal_m, jalr_m, lui_m, auipc_m, msz_m, rds_m, ill_m};
  assign obs_b = {pc_b, rs1_b, rs2_b, rd_b, imm_b, alu_b, opa_b, opb_b, rw_b, mr_b, mw_b,
                  br_b, jal_b, jalr_b, lui_b, auipc_b, msz_b, rds_b, ill_b};

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t       q[$];
  int          tests = 0, fails = 0;
  logic        held_prev = 1'b0;
  logic [99:0] saved_m, saved_b;

  // ALU code by funct3 for the base variant; the alternate (sub/sra) is one higher
  localparam logic [4:0] ALU_TBL [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};

  function automatic logic [99:0] ref_decode(input logic [31:0] i, input logic [31:0] pc, input bit en_m);
    logic [6:0]  opc, f7;
    logic [2:0]  f3, msz;
    logic [31:0] im_i, im_s, im_b, im_u, im_j, imm;
    logic [4:0]  alu;
    logic [1:0]  rds;
    logic        opa, opb, rw, mr, mw, br, j, jr, lu, au, ok;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    im_i = {{20{i[31]}}, i[31:20]};
    im_s = {{20{i[31]}}, i[31:25], i[11:7]};
    im_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    im_u = {i[31:12], 12'h000};
    im_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    imm = 0; alu = 0; rds = 0; msz = 0;
    opa = 0; opb = 0; rw = 0; mr = 0; mw = 0; br = 0; j = 0; jr = 0; lu = 0; au = 0; ok = 1;
    case (opc)
      7'b0110111: begin imm = im_u; rw = 1; lu = 1; rds = 2'b11; end
      7'b0010111: begin imm = im_u; opa = 1; opb = 1; rw = 1; au = 1; end
      7'b1101111: begin imm = im_j; opa = 1; opb = 1; rw = 1; j = 1; rds = 2'b10; end
      7'b1100111: begin imm = im_i; opb = 1; rw = 1; jr = 1; rds = 2'b10; ok = (f3 == 0); end
      7'b1100011: begin imm = im_b; opa = 1; opb = 1; br = 1; ok = !(f3 == 2 || f3 == 3); end
      7'b0000011: begin
        imm = im_i; opb = 1; rw = 1; mr = 1; rds = 2'b01; msz = f3;
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'b0100011: begin imm = im_s; opb = 1; mw = 1; msz = f3; ok = (f3 <= 2); end
      7'b0010011: begin
        imm = im_i; opb = 1; rw = 1; alu = ALU_TBL[f3];
        if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) begin
          if (f7 == 7'h20) alu = ALU_TBL[5] + 5'd1;
          else ok = (f7 == 0);
        end
      end
      7'b0110011: begin
        rw = 1;
        if (f7 == 0) alu = ALU_TBL[f3];
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) alu = ALU_TBL[f3] + 5'd1;
        else if (f7 == 7'h01 && en_m) alu = {2'b10, f3};
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin rw = 0; mr = 0; mw = 0; br = 0; j = 0; jr = 0; alu = 0; end
    return {pc, i[19:15], i[24:20], i[11:7], imm, alu, opa, opb, rw, mr, mw, br, j, jr, lu, au,
            msz, rds, ~ok};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] w;
    int          k, r;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = opcs[k];
    else if (k == 9) w[6:0] = 7'h33;
    r = $urandom_range(0, 3);
    if (r == 0) w[31:25] = 7'h00;
    else if (r == 1) w[31:25] = 7'h20;
    else if (r == 2) w[31:25] = 7'h01;
    return w;
  endfunction

  task automatic check(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, update the queue model
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl);
    int    cnt;
    item_t it;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    cnt = q.size();
    check("out_valid_m", {99'b0, vld_m}, {99'b0, cnt > 0});
    check("out_valid_b", {99'b0, vld_b}, {99'b0, cnt > 0});
    check("in_ready_m", {99'b0, rdy_m}, {99'b0, cnt < 2});
    check("in_ready_b", {99'b0, rdy_b}, {99'b0, cnt < 2});
    if (held_prev) begin
      check("hold_m", obs_m, saved_m);
      check("hold_b", obs_b, saved_b);
    end
    if (!fl && ordy && cnt > 0) begin
      it = q.pop_front();
      check("bundle_m", obs_m, ref_decode(it.instr, it.pc, 1'b1));
      check("bundle_b", obs_b, ref_decode(it.instr, it.pc, 1'b0));
    end
    if (fl) q.delete();
    else if (v && cnt < 2) q.push_back('{ins, pc});
    held_prev = (cnt > 0) && !ordy && !fl;
    saved_m = obs_m;
    saved_b = obs_b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bundle_m", obs_m, '0);
    check("rst_bundle_b", obs_b, '0);
    check("rst_valid", {99'b0, vld_m}, 100'd0);
    check("rst_ready", {99'b0, rdy_m}, 100'd1);
    rst_n = 1'b1;

    cyc(1, 32'h002081B3, 32'h100, 1, 0);
    check("add_valid", {99'b0, vld_m}, 100'd1);
    check("add_fields", {alu_m, rs1_m, rs2_m, rd_m, rw_m, opb_m}, {5'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0});
    cyc(1, 32'h402081B3, 32'h104, 1, 0);
    check("sub_alu", alu_m, 5'b00001);
    cyc(1, 32'h4020C1B3, 32'h108, 1, 0);
    check("bad_f7", {ill_m, rw_m}, 2'b10);
    cyc(1, 32'hFFC12283, 32'h10C, 1, 0);
    check("lw_fields", {imm_m, mr_m, msz_m, rds_m, opb_m}, {32'hFFFFFFFC, 1'b1, 3'b010, 2'b01, 1'b1});
    cyc(1, 32'h008000EF, 32'h110, 1, 0);
    check("jal_fields", {imm_m, jal_m, opa_m, rds_m}, {32'h00000008, 1'b1, 1'b1, 2'b10});
    cyc(1, 32'h022081B3, 32'h114, 1, 0);
    check("mul_m", {alu_m, ill_m}, {5'b10000, 1'b0});
    check("mul_base_illegal", ill_b, 1'b1);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Held output: 0x0 in output, 0x4 in skid, 0x8 waits upstream
    cyc(1, 32'h00100093, 32'h0, 0, 0);
    cyc(1, 32'h00200113, 32'h4, 0, 0);
    cyc(1, 32'h00300193, 32'h8, 0, 0);
    check("held_pc", pc_m, 32'h0);
    check("held_ready", rdy_m, 1'b0);
    cyc(1, 32'h00300193, 32'h8, 0, 0);
    cyc(1, 32'h00300193, 32'h8, 1, 0);
    cyc(1, 32'h00300193, 32'h8, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Flush with both entries full and an instruction offered
    cyc(1, 32'h00A00513, 32'h20, 0, 0);
    cyc(1, 32'h00B00593, 32'h24, 0, 0);
    cyc(1, 32'h00C00613, 32'h28, 0, 1);
    check("flush_valid", vld_m, 1'b0);
    check("flush_ready", rdy_m, 1'b1);
    cyc(1, 32'h00D00693, 32'h2C, 1, 1);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Asynchronous reset mid-stream, between clock edges
    cyc(1, 32'h00E00713, 32'h30, 0, 0);
    cyc(1, 32'h00F00793, 32'h34, 0, 0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {vld_m, vld_b}, 2'b00);
    check("arst_ready", rdy_m, 1'b1);
    q.delete();
    held_prev = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 32'h0, 32'h0, 1, 0);

    pc = 32'h1000;
    repeat (400) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), pc, $urandom_range(0, 9) < 7,
          $urandom_range(0, 49) == 0);
      pc += 4;
    end
    repeat (4) cyc(0, 32'h0, 32'h0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
